// File: rtl/hazard_unit.sv
// Pipeline hazard unit: data/HI-LO stall detection, D/E/M forwarding selects,
// multiply/divide busy tracking and a saturating stall-cycle counter.
module hazard_unit #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tuse_rs0,
    input  logic        tuse_rs1,
    input  logic        tuse_rt0,
    input  logic        tuse_rt1,
    input  logic        tuse_rt2,
    input  logic [4:0]  a1_d,
    input  logic [4:0]  a2_d,
    input  logic [4:0]  a1_e,
    input  logic [4:0]  a2_e,
    input  logic [4:0]  a3_e,
    input  logic [4:0]  a3_m,
    input  logic [4:0]  a2_m,
    input  logic [4:0]  a3_w,
    input  logic [1:0]  res_e,
    input  logic [1:0]  res_m,
    input  logic [1:0]  res_w,
    input  logic        md_start,
    input  logic        md_div,
    input  logic        md_use_d,
    output logic        stall,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic [1:0]  fwd_rt_m,
    output logic        md_busy,
    output logic [15:0] stall_count
);

    localparam logic [1:0] ResNw  = 2'b00;
    localparam logic [1:0] ResAlu = 2'b01;
    localparam logic [1:0] ResDm  = 2'b10;
    localparam logic [1:0] ResPc  = 2'b11;

    localparam logic [1:0] FwdNone = 2'b00;
    localparam logic [1:0] FwdE    = 2'b01;
    localparam logic [1:0] FwdM    = 2'b10;
    localparam logic [1:0] FwdW    = 2'b11;

    localparam logic [3:0] MultLoad = 4'(MULT_CYC);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYC);

    // True when a consumer needing src at tuse cannot yet be served by this producer.
    function automatic logic raw_hazard(input logic       use_v,
                                        input logic [1:0] tuse,
                                        input logic [4:0] src,
                                        input logic [4:0] dst,
                                        input logic [1:0] res,
                                        input logic [1:0] tnew);
        return use_v && (src != 5'd0) && (src == dst) && (res != ResNw) && (tnew > tuse);
    endfunction

    function automatic logic m_fwd_ok(input logic [4:0] src,
                                      input logic [4:0] a3,
                                      input logic [1:0] res);
        return (src == a3) && ((res == ResAlu) || (res == ResPc));
    endfunction

    function automatic logic w_fwd_ok(input logic [4:0] src,
                                      input logic [4:0] a3,
                                      input logic [1:0] res);
        return (src == a3) && (res != ResNw);
    endfunction

    function automatic logic [1:0] sel_d(input logic [4:0] src,
                                         input logic [4:0] a3e,
                                         input logic [1:0] rese,
                                         input logic [4:0] a3m,
                                         input logic [1:0] resm,
                                         input logic [4:0] a3w,
                                         input logic [1:0] resw);
        logic [1:0] sel;
        sel = FwdNone;
        if (src != 5'd0) begin
            if ((src == a3e) && (rese == ResPc)) begin
                sel = FwdE;
            end else if (m_fwd_ok(src, a3m, resm)) begin
                sel = FwdM;
            end else if (w_fwd_ok(src, a3w, resw)) begin
                sel = FwdW;
            end
        end
        return sel;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] src,
                                         input logic [4:0] a3m,
                                         input logic [1:0] resm,
                                         input logic [4:0] a3w,
                                         input logic [1:0] resw);
        logic [1:0] sel;
        sel = FwdNone;
        if (src != 5'd0) begin
            if (m_fwd_ok(src, a3m, resm)) begin
                sel = FwdM;
            end else if (w_fwd_ok(src, a3w, resw)) begin
                sel = FwdW;
            end
        end
        return sel;
    endfunction

    logic [1:0]  tnew_e;
    logic [1:0]  tnew_m;
    logic        rs_use;
    logic        rt_use;
    logic [1:0]  rs_tuse;
    logic [1:0]  rt_tuse;
    logic        data_stall;
    logic        md_stall;
    logic        busy_raw;
    logic [3:0]  md_cnt_q;
    logic [3:0]  md_cnt_d;
    logic [15:0] stall_count_q;
    logic [15:0] stall_count_d;

    always_comb begin
        unique case (res_e)
            ResAlu:  tnew_e = 2'd1;
            ResDm:   tnew_e = 2'd2;
            default: tnew_e = 2'd0;
        endcase
        tnew_m = (res_m == ResDm) ? 2'd1 : 2'd0;
    end

    // Earliest need wins when several Tuse flags are set.
    always_comb begin
        rs_use  = tuse_rs0 | tuse_rs1;
        rs_tuse = tuse_rs0 ? 2'd0 : 2'd1;
        rt_use  = tuse_rt0 | tuse_rt1 | tuse_rt2;
        rt_tuse = tuse_rt0 ? 2'd0 : (tuse_rt1 ? 2'd1 : 2'd2);
    end

    always_comb begin
        data_stall = raw_hazard(rs_use, rs_tuse, a1_d, a3_e, res_e, tnew_e)
                   | raw_hazard(rs_use, rs_tuse, a1_d, a3_m, res_m, tnew_m)
                   | raw_hazard(rt_use, rt_tuse, a2_d, a3_e, res_e, tnew_e)
                   | raw_hazard(rt_use, rt_tuse, a2_d, a3_m, res_m, tnew_m);
        busy_raw   = (md_cnt_q != 4'd0);
        md_stall   = md_use_d & (busy_raw | md_start);
    end

    // Outputs are forced inactive while reset is held low.
    always_comb begin
        stall    = reset & (data_stall | md_stall);
        md_busy  = reset & busy_raw;
        fwd_rs_d = FwdNone;
        fwd_rt_d = FwdNone;
        fwd_rs_e = FwdNone;
        fwd_rt_e = FwdNone;
        fwd_rt_m = FwdNone;
        if (reset) begin
            fwd_rs_d = sel_d(a1_d, a3_e, res_e, a3_m, res_m, a3_w, res_w);
            fwd_rt_d = sel_d(a2_d, a3_e, res_e, a3_m, res_m, a3_w, res_w);
            fwd_rs_e = sel_e(a1_e, a3_m, res_m, a3_w, res_w);
            fwd_rt_e = sel_e(a2_e, a3_m, res_m, a3_w, res_w);
            if ((a2_m != 5'd0) && w_fwd_ok(a2_m, a3_w, res_w)) begin
                fwd_rt_m = FwdW;
            end
        end
    end

    // A new mult/div is only accepted once the previous one has drained.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end else if (md_start) begin
            md_cnt_d = md_div ? DivLoad : MultLoad;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q      <= 4'd0;
            stall_count_q <= 16'd0;
        end else begin
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver pushes model predictions, monitor
// pops and compares each cycle. Directed scenarios, random traffic, saturation.
module tb_hazard_unit;

    logic        clk;
    logic        reset;
    logic        tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2;
    logic [4:0]  a1_d, a2_d, a1_e, a2_e, a3_e, a3_m, a2_m, a3_w;
    logic [1:0]  res_e, res_m, res_w;
    logic        md_start, md_div, md_use_d;
    logic        stall;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
    logic        md_busy;
    logic [15:0] stall_count;

    hazard_unit #(
        .MULT_CYC(5),
        .DIV_CYC (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tuse_rs0   (tuse_rs0),
        .tuse_rs1   (tuse_rs1),
        .tuse_rt0   (tuse_rt0),
        .tuse_rt1   (tuse_rt1),
        .tuse_rt2   (tuse_rt2),
        .a1_d       (a1_d),
        .a2_d       (a2_d),
        .a1_e       (a1_e),
        .a2_e       (a2_e),
        .a3_e       (a3_e),
        .a3_m       (a3_m),
        .a2_m       (a2_m),
        .a3_w       (a3_w),
        .res_e      (res_e),
        .res_m      (res_m),
        .res_w      (res_w),
        .md_start   (md_start),
        .md_div     (md_div),
        .md_use_d   (md_use_d),
        .stall      (stall),
        .fwd_rs_d   (fwd_rs_d),
        .fwd_rt_d   (fwd_rt_d),
        .fwd_rs_e   (fwd_rs_e),
        .fwd_rt_e   (fwd_rt_e),
        .fwd_rt_m   (fwd_rt_m),
        .md_busy    (md_busy),
        .stall_count(stall_count)
    );

    typedef struct packed {
        logic       rst_n;
        logic       tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2;
        logic [4:0] a1_d, a2_d, a1_e, a2_e, a3_e, a3_m, a2_m, a3_w;
        logic [1:0] res_e, res_m, res_w;
        logic       md_start, md_div, md_use_d;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic [1:0]  rs_d, rt_d, rs_e, rt_e, rt_m;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_err = 0;
    int         md_left = 0;
    int         scnt = 0;
    int         tnew_e_tab[4] = '{0, 1, 2, 0};
    int         tnew_m_tab[4] = '{0, 0, 1, 0};
    logic [4:0] pool[5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic int tuse_of(input logic z, input logic o, input logic t);
        if (z) return 0;
        if (o) return 1;
        if (t) return 2;
        return -1;
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] src, input stim_t s,
                                             input bit allow_e);
        if (src == 5'd0) return 2'b00;
        if (allow_e && src == s.a3_e && s.res_e == 2'b11) return 2'b01;
        if (src == s.a3_m && (s.res_m == 2'b01 || s.res_m == 2'b11)) return 2'b10;
        if (src == s.a3_w && s.res_w != 2'b00) return 2'b11;
        return 2'b00;
    endfunction

    task automatic drive(input stim_t s);
        reset    = s.rst_n;
        tuse_rs0 = s.tuse_rs0;
        tuse_rs1 = s.tuse_rs1;
        tuse_rt0 = s.tuse_rt0;
        tuse_rt1 = s.tuse_rt1;
        tuse_rt2 = s.tuse_rt2;
        a1_d     = s.a1_d;
        a2_d     = s.a2_d;
        a1_e     = s.a1_e;
        a2_e     = s.a2_e;
        a3_e     = s.a3_e;
        a3_m     = s.a3_m;
        a2_m     = s.a2_m;
        a3_w     = s.a3_w;
        res_e    = s.res_e;
        res_m    = s.res_m;
        res_w    = s.res_w;
        md_start = s.md_start;
        md_div   = s.md_div;
        md_use_d = s.md_use_d;
    endtask

    // Drive one cycle, predict its outputs, then advance the model to the next cycle.
    task automatic apply(input stim_t s);
        exp_t       e;
        int         tu[2];
        logic [4:0] src[2];
        bit         ds;
        @(posedge clk);
        #1;
        drive(s);
        e = '0;
        if (!s.rst_n) begin
            md_left = 0;
            scnt    = 0;
        end else begin
            tu[0]  = tuse_of(s.tuse_rs0, s.tuse_rs1, 1'b0);
            tu[1]  = tuse_of(s.tuse_rt0, s.tuse_rt1, s.tuse_rt2);
            src[0] = s.a1_d;
            src[1] = s.a2_d;
            ds     = 0;
            for (int i = 0; i < 2; i++) begin
                if (tu[i] >= 0 && src[i] != 5'd0) begin
                    if (s.res_e != 2'b00 && src[i] == s.a3_e && tnew_e_tab[s.res_e] > tu[i])
                        ds = 1;
                    if (s.res_m != 2'b00 && src[i] == s.a3_m && tnew_m_tab[s.res_m] > tu[i])
                        ds = 1;
                end
            end
            e.busy  = (md_left > 0);
            e.stall = ds || (s.md_use_d && (md_left > 0 || s.md_start));
            e.cnt   = 16'(scnt);
            e.rs_d  = fwd_model(s.a1_d, s, 1'b1);
            e.rt_d  = fwd_model(s.a2_d, s, 1'b1);
            e.rs_e  = fwd_model(s.a1_e, s, 1'b0);
            e.rt_e  = fwd_model(s.a2_e, s, 1'b0);
            e.rt_m  = (s.a2_m != 5'd0 && s.a2_m == s.a3_w && s.res_w != 2'b00) ? 2'b11 : 2'b00;
            if (e.stall && scnt < 65535) scnt++;
            if (md_left > 0) md_left--;
            else if (s.md_start) md_left = s.md_div ? 10 : 5;
        end
        exp_q.push_back(e);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s          = '0;
        s.rst_n    = ($urandom_range(199) != 0);
        s.tuse_rs0 = ($urandom_range(3) == 0);
        s.tuse_rs1 = ($urandom_range(2) == 0);
        s.tuse_rt0 = ($urandom_range(3) == 0);
        s.tuse_rt1 = ($urandom_range(3) == 0);
        s.tuse_rt2 = ($urandom_range(2) == 0);
        s.a1_d     = pool[3'($urandom_range(4))];
        s.a2_d     = pool[3'($urandom_range(4))];
        s.a1_e     = pool[3'($urandom_range(4))];
        s.a2_e     = pool[3'($urandom_range(4))];
        s.a3_e     = pool[3'($urandom_range(4))];
        s.a3_m     = pool[3'($urandom_range(4))];
        s.a2_m     = pool[3'($urandom_range(4))];
        s.a3_w     = pool[3'($urandom_range(4))];
        s.res_e    = 2'($urandom_range(3));
        s.res_m    = 2'($urandom_range(3));
        s.res_w    = 2'($urandom_range(3));
        s.md_start = ($urandom_range(7) == 0);
        s.md_div   = ($urandom_range(1) == 0);
        s.md_use_d = ($urandom_range(2) == 0);
        return s;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("stall",       16'(stall),    16'(mon_e.stall));
                check("fwd_rs_d",    16'(fwd_rs_d), 16'(mon_e.rs_d));
                check("fwd_rt_d",    16'(fwd_rt_d), 16'(mon_e.rt_d));
                check("fwd_rs_e",    16'(fwd_rs_e), 16'(mon_e.rs_e));
                check("fwd_rt_e",    16'(fwd_rt_e), 16'(mon_e.rt_e));
                check("fwd_rt_m",    16'(fwd_rt_m), 16'(mon_e.rt_m));
                check("md_busy",     16'(md_busy),  16'(mon_e.busy));
                check("stall_count", stall_count,   mon_e.cnt);
            end
        end
    end

    initial begin
        stim_t       s;
        logic [15:0] base;
        s = idle();
        s.rst_n = 1'b0;
        drive(s);
        apply(s);
        apply(s);

        // Load-use, then forward from W once the load retires.
        s = idle(); s.res_e = 2'b10; s.a3_e = 5'd5; s.a1_d = 5'd5; s.tuse_rs1 = 1'b1; apply(s);
        s = idle(); s.res_m = 2'b10; s.a3_m = 5'd5; s.a1_d = 5'd5; s.tuse_rs1 = 1'b1; apply(s);
        s = idle(); s.res_w = 2'b10; s.a3_w = 5'd5; s.a1_e = 5'd5; apply(s);
        // beq after ALU op.
        s = idle(); s.res_e = 2'b01; s.a3_e = 5'd3; s.a1_d = 5'd3; s.tuse_rs0 = 1'b1; apply(s);
        s = idle(); s.res_m = 2'b01; s.a3_m = 5'd3; s.a1_d = 5'd3; s.tuse_rs0 = 1'b1; apply(s);
        // jal then jr.
        s = idle(); s.res_e = 2'b11; s.a3_e = 5'd31; s.a1_d = 5'd31; s.tuse_rs0 = 1'b1; apply(s);
        // Register 0 never stalls or forwards.
        s = idle(); s.res_e = 2'b10; s.a3_e = 5'd0; s.a1_d = 5'd0; s.tuse_rs0 = 1'b1; apply(s);
        // rt path and M-stage rt forward.
        s = idle(); s.res_w = 2'b01; s.a3_w = 5'd7; s.a2_m = 5'd7; s.a2_d = 5'd7;
        s.tuse_rt2 = 1'b1; s.a2_e = 5'd7; apply(s);

        // Divide with a HI/LO consumer waiting in D.
        s = idle(); s.md_start = 1'b1; s.md_div = 1'b1; s.md_use_d = 1'b1; apply(s);
        base = stall_count;
        for (int i = 0; i < 10; i++) begin
            s = idle(); s.md_use_d = 1'b1; s.md_start = (i == 3); apply(s);
        end
        s = idle(); s.md_use_d = 1'b1; apply(s);
        check("div stall delta", stall_count - base, 16'd11);

        // Multiply, then reset at busy cycle 4 of a divide.
        s = idle(); s.md_start = 1'b1; apply(s);
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.md_use_d = 1'b1; apply(s);
        end
        s = idle(); s.md_start = 1'b1; s.md_div = 1'b1; s.md_use_d = 1'b1; apply(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.md_use_d = 1'b1; apply(s);
        end
        s = idle(); s.md_use_d = 1'b1; s.rst_n = 1'b0; apply(s);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.md_use_d = 1'b1; apply(s);
        end

        for (int i = 0; i < 3000; i++) apply(rand_stim());

        // Hold a data stall long enough to saturate the counter, then clear it.
        s = idle(); s.rst_n = 1'b0; apply(s);
        s = idle(); s.res_e = 2'b10; s.a3_e = 5'd9; s.a1_d = 5'd9; s.tuse_rs0 = 1'b1;
        for (int i = 0; i < 65540; i++) apply(s);
        s.rst_n = 1'b0; apply(s);
        s.rst_n = 1'b1; apply(s);
        apply(s);

        @(posedge clk);
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL provide parameters: MULT_CYC, default 5, busy cycles after a multiply start; DIV_CYC, default 10, busy cycles after a divide start.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports: clk, in, 1, pipeline clock; reset, in, 1, asynchronous active-low reset.
REQ-004 SHALL have inputs tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2, each 1 bit: D-stage operand-need class (rs needed at 0/1 cycles, rt needed at 0/1/2 cycles).
REQ-005 SHALL have inputs a1_d and a2_d, 5 bits each: D-stage rs and rt.
REQ-006 SHALL have inputs a1_e, a2_e, a3_e, a3_m, a2_m and a3_w, 5 bits each: E/M/W source and destination registers.
REQ-007 SHALL have inputs res_e, res_m and res_w, 2 bits each, with encoding 00 nw, 01 alu, 10 dm, 11 pc.
REQ-008 SHALL have input md_start, 1 bit: E stage issues mult/div this cycle.
REQ-009 SHALL have input md_div, 1 bit: the md_start operation is a divide.
REQ-010 SHALL have input md_use_d, 1 bit: the D-stage instruction accesses the HI/LO unit.
REQ-011 SHALL have output stall, 1 bit: freeze F/D and insert a bubble into E; it is the stall input of the tag pipeline.
REQ-012 SHALL have outputs fwd_rs_d and fwd_rt_d, 2 bits each: 00 RF, 01 E, 10 M, 11 W.
REQ-013 SHALL have outputs fwd_rs_e and fwd_rt_e, 2 bits each: 00 pipe, 10 M, 11 W.
REQ-014 SHALL have output fwd_rt_m, 2 bits: 00 pipe, 11 W.
REQ-015 SHALL have output md_busy, 1 bit: the HI/LO unit is occupied.
REQ-016 SHALL have output stall_count, 16 bits: number of stall cycles, saturating.

Function
REQ-017 SHALL derive Tnew from res: E stage gives alu 1, dm 2, pc 0; M stage gives dm 1, otherwise 0; W stage gives 0; nw means no producer.
REQ-018 SHALL take Tuse for rs as 0 if tuse_rs0, else 1 if tuse_rs1, else no use; for rt as 0/1/2 from tuse_rt0/1/2, else no use.
REQ-019 SHALL assert the data-stall term when, for rs or rt with a use, the register is nonzero, equals a3_e (res_e != nw) or a3_m (res_m != nw), and that stage's Tnew > Tuse.
REQ-020 SHALL assert the md-stall term when md_use_d=1 and (md_busy=1 or md_start=1).
REQ-021 SHALL drive stall = data-stall term OR md-stall term, combinationally, in the same cycle.
REQ-022 SHALL drive each D-stage select with priority E > M > W > RF:
- E when a3_e matches and res_e = pc;
- M when a3_m matches and res_m is alu or pc;
- W when a3_w matches and res_w != nw;
- register 0 never forwards.
REQ-023 SHALL drive each E-stage select (a1_e/a2_e) with priority M > W > pipe, using the same M/W match rules as REQ-022.
REQ-024 SHALL drive fwd_rt_m = 11 when a2_m is nonzero, equals a3_w and res_w != nw; otherwise 00.
REQ-025 SHALL drive all forward selects independently of stall.
REQ-026 SHALL load a 4-bit down-counter, when md_start=1 and the counter is 0, with MULT_CYC or DIV_CYC (per md_div) on the next edge.
REQ-027 SHALL, on each edge while the counter is nonzero, decrement the counter and ignore md_start.
REQ-028 SHALL drive md_busy = (counter != 0).
REQ-029 SHALL count, at each edge with stall=1, stall_count up by 1, holding at 16'hFFFF.

Reset
REQ-030 SHALL, while reset=0, asynchronously clear the md counter and stall_count.
REQ-031 SHALL, while reset=0, force stall=0, md_busy=0 and all fwd selects to 00.
REQ-032 SHALL, when reset is asserted mid-operation, abandon any md operation; it does not resume.
REQ-033 SHALL resume normal operation on the first rising edge after reset returns to 1.

Verification
REQ-034 SHALL cover load-use: res_e=10, a3_e=5, a1_d=5, tuse_rs1=1 -> stall=1; next cycle res_m=10, a3_m=5, res_e=00 -> stall=0, fwd_rs_d=00 and fwd_rs_e=11 once the load reaches W.
REQ-035 SHALL cover beq after ALU: res_e=01, a3_e=3, a1_d=3, tuse_rs0=1 -> stall=1; with res_m=01, a3_m=3 -> stall=0, fwd_rs_d=10.
REQ-036 SHALL cover jal then jr: res_e=11, a3_e=31, a1_d=31, tuse_rs0=1 -> stall=0, fwd_rs_d=01.
REQ-037 SHALL cover register 0: a3_e=0, res_e=10, a1_d=0, tuse_rs0=1 -> stall=0, fwd_rs_d=00.
REQ-038 SHALL cover divide: md_start=1, md_div=1 -> md_busy=1 for exactly 10 cycles; md_use_d=1 throughout -> stall=1 on those cycles and on the start cycle; stall_count increments by 11.
REQ-039 SHALL cover reset mid-divide: reset=0 at busy cycle 4 -> md_busy=0 and stall_count=0 immediately, with no stall after release.
